// File: rtl/ccff_chain_loader.sv
// Streams valid/ready bitstream words MSB-first into the configuration chain and gates its clock.
// Define CCFF_LOADER_VERIFY_EN to add a rotating read-back pass with a CRC-16-CCITT compare.
module ccff_chain_loader #(
    parameter  int unsigned CHAIN_LEN = 1024,
    parameter  int unsigned WORD_W    = 8,
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic              verify_err
);

    localparam int unsigned BL_W  = $clog2(WORD_W + 1);
    localparam int unsigned SUM_W = ((CNT_W > BL_W) ? CNT_W : BL_W) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd3;
`ifdef CCFF_LOADER_VERIFY_EN
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
`endif

    logic [1:0]        state_q,     state_d;
    logic [WORD_W-1:0] word_q,      word_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;

`ifdef CCFF_LOADER_VERIFY_EN
    logic [15:0] crc_load_q, crc_load_d;
    logic [15:0] crc_chk_q,  crc_chk_d;
    logic        verify_err_q, verify_err_d;
    logic        in_verify;

    // One serial step of CRC-16-CCITT, polynomial 0x1021
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction
`endif

    logic             shift_load;
    logic [SUM_W-1:0] pending;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_bit;

    assign shift_load = (state_q == S_LOAD) && (bits_left_q != '0);
    assign pending    = SUM_W'(bit_count_q) + SUM_W'(bits_left_q);
    assign cnt_inc    = bit_count_q + CNT_W'(1);
    assign last_bit   = (cnt_inc == CNT_W'(CHAIN_LEN));

    // Refill while empty or on the last buffered bit, but never beyond the chain length
    assign in_ready = (state_q == S_LOAD) && (bits_left_q <= BL_W'(1))
                      && (pending < SUM_W'(CHAIN_LEN));

    assign done      = (state_q == S_DONE);
    assign bit_count = bit_count_q;

`ifdef CCFF_LOADER_VERIFY_EN
    // Read-back rotates the tail into the head so chain contents survive the check
    assign in_verify     = (state_q == S_VERIFY);
    assign ccff_head     = in_verify ? ccff_tail : word_q[WORD_W-1];
    assign ccff_shift_en = shift_load | in_verify;
    assign busy          = (state_q == S_LOAD) | in_verify;
    assign verify_err    = verify_err_q;
`else
    logic tail_unused;
    assign tail_unused   = ccff_tail;
    assign ccff_head     = word_q[WORD_W-1];
    assign ccff_shift_en = shift_load;
    assign busy          = (state_q == S_LOAD);
    assign verify_err    = 1'b0;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        bits_left_d = bits_left_q;
        bit_count_d = bit_count_q;
`ifdef CCFF_LOADER_VERIFY_EN
        crc_load_d   = crc_load_q;
        crc_chk_d    = crc_chk_q;
        verify_err_d = verify_err_q;
`endif
        if (abort) begin
            state_d     = S_IDLE;
            word_d      = '0;
            bits_left_d = '0;
            bit_count_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_LOAD;
                        word_d      = '0;
                        bits_left_d = '0;
                        bit_count_d = '0;
`ifdef CCFF_LOADER_VERIFY_EN
                        verify_err_d = 1'b0;
                        crc_load_d   = CRC_INIT;
`endif
                    end
                end
                S_LOAD: begin
                    if (shift_load) begin
                        word_d      = word_q << 1;
                        bits_left_d = bits_left_q - BL_W'(1);
                        bit_count_d = cnt_inc;
`ifdef CCFF_LOADER_VERIFY_EN
                        crc_load_d  = crc_step(crc_load_q, word_q[WORD_W-1]);
`endif
                    end
                    if (in_valid && in_ready) begin
                        word_d      = in_data;
                        bits_left_d = BL_W'(WORD_W);
                    end
                    // Final chain bit: drop any leftover bits of the last word
                    if (shift_load && last_bit) begin
                        word_d      = '0;
                        bits_left_d = '0;
`ifdef CCFF_LOADER_VERIFY_EN
                        state_d     = S_VERIFY;
                        bit_count_d = '0;
                        crc_chk_d   = CRC_INIT;
`else
                        state_d     = S_DONE;
`endif
                    end
                end
`ifdef CCFF_LOADER_VERIFY_EN
                S_VERIFY: begin
                    bit_count_d = cnt_inc;
                    crc_chk_d   = crc_step(crc_chk_q, ccff_tail);
                    if (last_bit) begin
                        state_d      = S_DONE;
                        verify_err_d = (crc_step(crc_chk_q, ccff_tail) != crc_load_q);
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            bits_left_q <= '0;
            bit_count_q <= '0;
`ifdef CCFF_LOADER_VERIFY_EN
            crc_load_q   <= CRC_INIT;
            crc_chk_q    <= CRC_INIT;
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            bits_left_q <= bits_left_d;
            bit_count_q <= bit_count_d;
`ifdef CCFF_LOADER_VERIFY_EN
            crc_load_q   <= crc_load_d;
            crc_chk_q    <= crc_chk_d;
            verify_err_q <= verify_err_d;
`endif
        end
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequences the configuration-chain flops: takes bitstream words over a valid/ready stream and serialises them MSB-first onto the chain head.
- Drives the clock-enable for the chain's prog_clk, counts shifted bits and stops after exactly CHAIN_LEN bits.
- Sits between the configuration port and the first chain segment (the first mux memory block's ccff_head); ccff_tail of the last segment returns here.

Parameters:
CHAIN_LEN, 1024, total configuration bits in the chain (>=2)
WORD_W, 8, bitstream input word width (>=1)
CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived, not overridden)

Ports:
prog_clk  in  1  configuration clock; all state on rising edge
prog_rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse: begin a load (ignored unless IDLE or DONE)
abort  in  1  level: return to IDLE next cycle, chain contents undefined
in_data  in  WORD_W  bitstream word, bit WORD_W-1 shifted first
in_valid  in  1  in_data valid
in_ready  out  1  word accepted when in_valid & in_ready
ccff_head  out  1  serial data to chain head
ccff_shift_en  out  1  chain clock-enable; chain captures ccff_head on the prog_clk edge where this is 1
ccff_tail  in  1  serial data from chain tail (used only with verify)
busy  out  1  high in LOAD/VERIFY
done  out  1  high in DONE until next start/abort
bit_count  out  CNT_W  bits shifted in current load
verify_err  out  1  sticky verify failure (0 when feature compiled out)

Behaviour:
- Reset (prog_rst_n=0, async): state IDLE; in_ready=0, ccff_shift_en=0, ccff_head=0, busy=0, done=0, bit_count=0, verify_err=0, word buffer empty.
- States: IDLE, LOAD, VERIFY (only with the feature), DONE.
- IDLE/DONE + start: go to LOAD; clear bit_count, done and verify_err; buffer empty.
- LOAD:
  - Holds a one-word buffer with a bits_left counter.
  - in_ready = (bits_left==0) | (bits_left==1 & ccff_shift_en), and bit_count + bits_left < CHAIN_LEN. This allows back-to-back words with no bubble.
  - ccff_shift_en = (bits_left!=0); ccff_head = buffer MSB. Both are decoded from registered state, never from in_valid.
  - Each shift cycle: buffer shifts left, bits_left-1, bit_count+1.
  - Empty buffer with in_valid=0 stalls: shift_en=0, chain holds.
  - When bit_count reaches CHAIN_LEN, the next state is VERIFY if enabled, else DONE. Remaining bits of the final word are discarded (CHAIN_LEN need not be a multiple of WORD_W).
  - No word is accepted after the final bit; in_ready=0.
- DONE: done=1, shift_en=0, in_ready=0; a new start begins a fresh load.
- abort: highest priority in any state; next state IDLE, all outputs as reset except verify_err, which holds.
- start while in LOAD/VERIFY: ignored.
- Latency: first bit reaches the chain on the edge after the first word is accepted. A full load takes CHAIN_LEN shift cycles plus stalls; DONE follows one cycle after the last shift (or after VERIFY).

Optional Feature:
- Macro: CCFF_LOADER_VERIFY_EN.
- With it:
  - During LOAD, a CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulates every shifted ccff_head bit.
  - VERIFY then runs exactly CHAIN_LEN shift cycles with ccff_head = ccff_tail (rotation, so contents are preserved).
  - A second CRC accumulates ccff_tail over those cycles; bit_count counts 0..CHAIN_LEN again.
  - On completion, verify_err=1 if the CRCs differ; enter DONE.
- Without it: no VERIFY state; verify_err tied 0; ccff_tail unused.

Test Plan:
- CHAIN_LEN=6, WORD_W=4, in_valid always 1, words 0xB then 0x4 -> shift_en high 6 consecutive cycles, head sequence 1,0,1,1,0,1; chain mem_out[0:5] = 1,0,1,1,0,1; low 2 bits of 0x4 dropped; done=1, bit_count=6.
- Same load with in_valid low 3 cycles between words -> shift_en low exactly 3 cycles, same final chain contents, bit_count frozen at 4 during the stall.
- Assert abort at bit_count=3 -> IDLE next cycle, shift_en=0, busy=0, done=0; a following start plus full load gives correct contents.
- prog_rst_n low mid-LOAD (asynchronously, between edges) -> all outputs reset immediately; start after release loads correctly.
- Pulse start in LOAD at bit_count=2 -> ignored, load completes with 6 bits; a second start in DONE reloads new data 0x5,0x8 -> chain 0,1,0,1,1,0.
- With CCFF_LOADER_VERIFY_EN, CHAIN_LEN=6, a healthy chain -> 6 VERIFY shifts, contents unchanged, verify_err=0. Force one chain flop stuck-at-0 -> verify_err=1 in DONE.
